// File: rtl/key_evt_pkg.sv
// ---------------------------------------------------------------------------
// key_evt_pkg
// Shared definitions for the key event decoder:
//   state_t   - decoder FSM states
//   MODE_W    - width of the loop-mode index
//   MODE_RST  - loop-mode value after reset and after a long press
//   nextMode  - loop-mode update for one cycle's decoded event
// ---------------------------------------------------------------------------
package key_evt_pkg;

  localparam int MODE_W = 2;
  localparam logic [MODE_W-1:0] MODE_RST = '0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_WAIT2     = 3'd2,
    ST_PRESS2    = 3'd3,
    ST_LONG_HOLD = 3'd4
  } state_t;

  // Single steps forward, double steps back, long returns to the start.
  // Both directions wrap naturally in MODE_W bits.
  function automatic logic [MODE_W-1:0] nextMode(
    input logic [MODE_W-1:0] cur,
    input logic              isSingle,
    input logic              isDouble,
    input logic              isLong
  );
    logic [MODE_W-1:0] result;
    result = cur;
    if (isLong) begin
      result = MODE_RST;
    end else if (isDouble) begin
      result = cur - MODE_W'(1);
    end else if (isSingle) begin
      result = cur + MODE_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/key_evt_timer.sv
// ---------------------------------------------------------------------------
// key_evt_timer
// 32-bit saturating cycle counter shared by all decoder states.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset, counter to 0
//   i_clear  - synchronous clear (counter restarts at 0 next cycle)
//   i_tc     - terminal count to compare against
//   o_tc_hit - high while the counter is at or beyond i_tc
// ---------------------------------------------------------------------------
module key_evt_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic [31:0] i_tc,
  output logic        o_tc_hit
);

  logic [31:0] r_count;

  // Counter holds at all-ones instead of wrapping, so a state that sits
  // for a very long time never sees the terminal count a second time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (r_count != 32'hFFFF_FFFF) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_tc_hit = (r_count >= i_tc);

endmodule

// File: rtl/key_event_decoder.sv
// ---------------------------------------------------------------------------
// key_event_decoder
// Classifies debounced key activity into single click, double click and
// long press, and steps a loop-mode index from those events.
// Parameters:
//   DBL_WIN  - max cycles from first release to second press for a double
//   LONG_CNT - cycles a first press must be held to count as long
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   key_press  - one-cycle pulse per debounced press
//   key_held   - level, high while the key is down
//   evt_single - one-cycle registered pulse, single click
//   evt_double - one-cycle registered pulse, double click
//   evt_long   - one-cycle registered pulse, long press
//   mode       - loop-mode index, changes in the same cycle as its event
// Build option:
//   KEY_EVT_LONG_EN - when defined, long-press detection is built; when
//   undefined, a held press of any length is a single/double click and
//   evt_long is constant 0.
// ---------------------------------------------------------------------------
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int unsigned DBL_WIN  = 5_000_000,
  parameter int unsigned LONG_CNT = 20_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_press,
  input  logic              key_held,
  output logic              evt_single,
  output logic              evt_double,
  output logic              evt_long,
  output logic [MODE_W-1:0] mode
);

  localparam logic [31:0] DBL_TC  = 32'(DBL_WIN - 1);
  localparam logic [31:0] LONG_TC = 32'(LONG_CNT - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic              w_single;
  logic              w_double;
  logic              w_long;
  logic              r_single;
  logic              r_double;
  logic [MODE_W-1:0] r_mode;
  logic [31:0]       w_tc;
  logic              w_tcHit;
  logic              w_timerClear;

  // Only PRESS1 looks at the long-press limit; every other state that cares
  // about time is waiting for the double-click window to close.
  assign w_tc = (r_state == ST_PRESS1) ? LONG_TC : DBL_TC;

  // Any state change restarts the shared timer from zero.
  assign w_timerClear = (w_nextState != r_state);

  key_evt_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_timerClear),
    .i_tc     (w_tc),
    .o_tc_hit (w_tcHit)
  );

  // Next-state and event decode. Priority inside a state resolves the
  // same-cycle races: a release beats the long limit, and a second press
  // beats the closing of the double-click window.
  always_comb begin
    w_nextState = r_state;
    w_single    = 1'b0;
    w_double    = 1'b0;
    w_long      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (key_press) begin
          w_nextState = ST_PRESS1;
        end
      end
      ST_PRESS1: begin
        if (!key_held) begin
          w_nextState = ST_WAIT2;
        end
`ifdef KEY_EVT_LONG_EN
        else if (w_tcHit) begin
          w_long      = 1'b1;
          w_nextState = ST_LONG_HOLD;
        end
`endif
      end
      ST_WAIT2: begin
        if (key_press) begin
          w_double    = 1'b1;
          w_nextState = ST_PRESS2;
        end else if (w_tcHit) begin
          w_single    = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        if (!key_held) begin
          w_nextState = ST_IDLE;
        end
      end
`ifdef KEY_EVT_LONG_EN
      ST_LONG_HOLD: begin
        if (!key_held) begin
          w_nextState = ST_IDLE;
        end
      end
`endif
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State, event pulses and mode all register together so that mode
  // changes in exactly the cycle its event pulse is visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_mode   <= MODE_RST;
    end else begin
      r_state  <= w_nextState;
      r_single <= w_single;
      r_double <= w_double;
      r_mode   <= nextMode(r_mode, w_single, w_double, w_long);
    end
  end

`ifdef KEY_EVT_LONG_EN
  logic r_long;

  // Long-press pulse register, only present when the feature is built.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_long <= 1'b0;
    end else begin
      r_long <= w_long;
    end
  end

  assign evt_long = r_long;
`else
  assign evt_long = 1'b0;
`endif

  assign evt_single = r_single;
  assign evt_double = r_double;
  assign mode       = r_mode;

endmodule

// File: tb/tb_key_event_decoder.sv
// ---------------------------------------------------------------------------
// tb_key_event_decoder
// Self-checking bench for key_event_decoder with DBL_WIN=20, LONG_CNT=50.
// Each scenario is a list of gestures (press cycle, hold length) plus stray
// presses that must be ignored. An event-timing model computes, from the
// gesture timeline alone, the cycle and kind of every expected event and
// the resulting mode; the DUT outputs are compared every cycle.
// Honours KEY_EVT_LONG_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_key_event_decoder;

  localparam int DBL_WIN  = 20;
  localparam int LONG_CNT = 50;
  localparam int MAXC     = 8192;
`ifdef KEY_EVT_LONG_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  localparam int EV_NONE   = 0;
  localparam int EV_SINGLE = 1;
  localparam int EV_DOUBLE = 2;
  localparam int EV_LONG   = 3;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       key_press = 1'b0;
  logic       key_held  = 1'b0;
  logic       evt_single;
  logic       evt_double;
  logic       evt_long;
  logic [1:0] mode;

  int passCount  = 0;
  int checkCount = 0;

  bit         pressSched[MAXC];
  bit         heldSched[MAXC];
  int         evtSched[MAXC];
  logic [1:0] modeSched[MAXC];

  int gPress[$];
  int gHold[$];
  int strays[$];

  always #5 clk = ~clk;

  key_event_decoder #(
    .DBL_WIN  (DBL_WIN),
    .LONG_CNT (LONG_CNT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_press  (key_press),
    .key_held   (key_held),
    .evt_single (evt_single),
    .evt_double (evt_double),
    .evt_long   (evt_long),
    .mode       (mode)
  );

  // Single comparison point: {single, double, long, mode[1:0]}.
  task automatic checkOutput(input string tag, input logic [4:0] obs, input logic [4:0] expVal);
    checkCount++;
    if (obs === expVal) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got s/d/l/mode=%b expected %b", tag, obs, expVal);
    end
  endtask

  function automatic void clearGestures();
    gPress.delete();
    gHold.delete();
    strays.delete();
  endfunction

  function automatic void addGesture(input int p, input int h);
    gPress.push_back(p);
    gHold.push_back(h);
  endfunction

  function automatic void emitEvent(input int c, input int code);
    if (c >= 0 && c < MAXC) evtSched[c] = code;
  endfunction

  // Event-timing model. A press is "released" on the first cycle key_held
  // is seen low after it, at least one cycle later. A first press held more
  // than LONG_CNT cycles is long (event LONG_CNT+1 cycles after the press).
  // Otherwise a second press no later than DBL_WIN cycles after the release
  // is a double (event the cycle after that press); failing that a single
  // fires DBL_WIN+1 cycles after the release. A press is only considered
  // once the previous gesture has fully finished.
  function automatic void buildModel();
    int  nextReady;
    int  rel;
    bit  waiting;
    int  m;
    for (int c = 0; c < MAXC; c++) begin
      pressSched[c] = 1'b0;
      heldSched[c]  = 1'b0;
      evtSched[c]   = EV_NONE;
    end
    foreach (gPress[i]) begin
      pressSched[gPress[i]] = 1'b1;
      for (int k = 0; k < gHold[i]; k++) heldSched[gPress[i] + k] = 1'b1;
    end
    foreach (strays[i]) pressSched[strays[i]] = 1'b1;

    nextReady = 0;
    waiting   = 1'b0;
    rel       = 0;
    foreach (gPress[i]) begin
      int p;
      int r;
      p = gPress[i];
      r = p + ((gHold[i] < 1) ? 1 : gHold[i]);
      if (waiting) begin
        waiting = 1'b0;
        if (p <= rel + DBL_WIN) begin
          emitEvent(p + 1, EV_DOUBLE);
          nextReady = r + 1;
          continue;
        end
        emitEvent(rel + DBL_WIN + 1, EV_SINGLE);
        nextReady = rel + DBL_WIN + 1;
      end
      if (p < nextReady) continue;
      if (LONG_EN && gHold[i] > LONG_CNT) begin
        emitEvent(p + LONG_CNT + 1, EV_LONG);
        nextReady = r + 1;
      end else begin
        waiting = 1'b1;
        rel     = r;
      end
    end
    if (waiting) emitEvent(rel + DBL_WIN + 1, EV_SINGLE);

    m = 0;
    for (int c = 0; c < MAXC; c++) begin
      case (evtSched[c])
        EV_SINGLE: m = (m + 1) % 4;
        EV_DOUBLE: m = (m + 3) % 4;
        EV_LONG:   m = 0;
        default:   m = m;
      endcase
      modeSched[c] = 2'(m);
    end
  endfunction

  function automatic logic [4:0] expectedVec(input int c);
    return {evtSched[c] == EV_SINGLE, evtSched[c] == EV_DOUBLE,
            evtSched[c] == EV_LONG, modeSched[c]};
  endfunction

  task automatic applyStimulus(input int c);
    key_press = pressSched[c];
    key_held  = heldSched[c];
  endtask

  // One-cycle reset; everything must read back as zero after it.
  task automatic doReset(input string name);
    @(negedge clk);
    rst_n     = 1'b0;
    key_press = 1'b0;
    key_held  = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({name, " reset"}, {evt_single, evt_double, evt_long, mode}, 5'b0);
  endtask

  // Cycle 0 inputs are applied together with reset release.
  task automatic runScenario(input string name, input int len);
    buildModel();
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(c);
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s c%0d", name, c + 1),
                  {evt_single, evt_double, evt_long, mode}, expectedVec(c + 1));
    end
  endtask

  task automatic buildRandom();
    int p;
    int h;
    int g;
    int r;
    int sel;
    clearGestures();
    p = 0;
    r = 0;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      h = 0;
      else if (sel <= 5) h = $urandom_range(1, 10);
      else if (sel <= 7) h = $urandom_range(45, 60);
      else               h = $urandom_range(11, 30);
      addGesture(p, h);
      if (h >= 3 && $urandom_range(0, 2) == 0) strays.push_back(p + 1);
      r = p + ((h < 1) ? 1 : h);
      sel = $urandom_range(0, 9);
      if (sel <= 5)      g = $urandom_range(1, DBL_WIN);
      else if (sel == 6) g = DBL_WIN;
      else if (sel == 7) g = DBL_WIN + 1;
      else               g = $urandom_range(DBL_WIN + 2, 40);
      p = r + g;
    end
  endtask

  int lastLen;

  initial begin
    $display("[TB] key_event_decoder bench, long-press build = %0d", LONG_EN);

    doReset("single");
    clearGestures(); addGesture(0, 5);
    runScenario("single", 40);

    doReset("double");
    clearGestures(); addGesture(0, 5); addGesture(13, 3);
    strays.push_back(2); strays.push_back(14);
    runScenario("double", 40);

    doReset("long60");
    clearGestures(); addGesture(0, 60); strays.push_back(55);
    runScenario("long60", 100);

    doReset("hold50");
    clearGestures(); addGesture(0, 50);
    runScenario("hold50", 90);

    doReset("hold51");
    clearGestures(); addGesture(0, 51);
    runScenario("hold51", 90);

    doReset("edgeDbl");
    clearGestures(); addGesture(0, 5); addGesture(25, 2);
    runScenario("edgeDbl", 40);

    doReset("edgeSgl");
    clearGestures(); addGesture(0, 5); addGesture(26, 2);
    runScenario("edgeSgl", 60);

    doReset("noHeld");
    clearGestures(); addGesture(0, 0); addGesture(3, 0);
    runScenario("noHeld", 20);

    // Two singles bring mode to 2, then a third click is cut off by reset
    // while waiting for a second press.
    doReset("preRst");
    clearGestures(); addGesture(0, 1); addGesture(30, 2); addGesture(60, 5);
    runScenario("preRst", 72);
    doReset("midWait");
    clearGestures(); addGesture(2, 5);
    runScenario("postRst", 40);

    for (int s = 0; s < 3; s++) begin
      doReset($sformatf("rand%0d", s));
      buildRandom();
      lastLen = gPress[gPress.size() - 1] + gHold[gHold.size() - 1] + DBL_WIN + 12;
      runScenario($sformatf("rand%0d", s), lastLen);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
